smpl_window_queue: RTL and testbench

//  Parametrised multi-channel circular sample queue feeding the FIR sequencer.
//  - Stores the last DEPTH audio samples per channel.
//  - Once WIN samples are held, each new sample triggers a burst replaying the
//    WIN most recent samples, oldest first, with a sequencing strobe.
//  - Adds a one-deep pending trigger and sticky overrun reporting.

---
 rtl/smpl_q_pkg.sv | 14 +
 rtl/smpl_window_queue_dp_ram.sv | 42 ++++
 rtl/smpl_window_queue.sv | 182 ++++++++++++++++++
 tb/tb_smpl_window_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smpl_q_pkg.sv
// rtl/smpl_q_pkg.sv - shared types for the multi-channel sample window queue
//
// Holds the burst sequencer state encoding used by smpl_window_queue.
// Pointer and counter widths depend on the DEPTH/WIN parameters, so they are
// derived inside the modules rather than here.
package smpl_q_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/smpl_window_queue_dp_ram.sv
// rtl/smpl_window_queue_dp_ram.sv - simple dual-port sample RAM, registered read
//
// One write port and one read port on the same clock. The read data register
// updates only when re_i is high and otherwise holds its last value. No reset:
// contents and read data are undefined until written/read.
//
// Ports:
//   clk      in   system clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable
//   raddr_i  in   read address
//   rdata_o  out  registered read data (one cycle after re_i)
module dp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/smpl_window_queue.sv
// rtl/smpl_window_queue.sv - multi-channel circular sample queue with windowed replay
//
// Keeps the last DEPTH samples per channel. Once WIN samples are held, every
// new sample triggers a burst that replays the WIN most recent samples, oldest
// first, with sequencing high for exactly WIN consecutive cycles. One trigger
// arriving during a burst is held as pending; a further one is dropped and
// sets the sticky ovr flag.
//
// Optional build macro: QUEUE_FLUSH_EN adds the flush port (synchronous
// return to IDLE with an empty window; wr_ptr kept).
//
// Ports:
//   clk         in   system clock, posedge
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous flush (QUEUE_FLUSH_EN builds only)
//   wrt_smpl    in   one-cycle strobe, write smpl_in
//   smpl_in     in   packed samples, ch0 in [DATA_W-1:0]
//   smpl_out    out  replayed samples, same packing
//   sequencing  out  smpl_out valid (burst active)
//   last        out  newest sample of the burst
//   ovr         out  sticky trigger-lost flag
module smpl_window_queue
  import smpl_q_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024,
  parameter int WIN    = 1021
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef QUEUE_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     wrt_smpl,
  input  logic [NUM_CH*DATA_W-1:0] smpl_in,
  output logic [NUM_CH*DATA_W-1:0] smpl_out,
  output logic                     sequencing,
  output logic                     last,
  output logic                     ovr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WIN + 1);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] WIN_M1  = PTR_W'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WIN = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] CNT_TRG = CNT_W'(WIN - 1);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              pending_q, pending_d;
  logic              ovr_q, ovr_d;

  logic              flush_w;
  logic              trigger;
  logic [PTR_W-1:0]  newest_ptr;
  logic [PTR_W-1:0]  win_start;
  logic              ram_re;

`ifdef QUEUE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign trigger = wrt_smpl & (fill_q >= CNT_TRG);

  // Newest sample is the one written this cycle if any, otherwise the one
  // just behind wr_ptr. A pending reload at burst end may see either case.
  assign newest_ptr = wrt_smpl ? wr_ptr_q : (wr_ptr_q - PTR_ONE);
  assign win_start  = newest_ptr - WIN_M1;

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rem_d     = rem_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    ram_re    = 1'b0;
    wr_ptr_d  = wrt_smpl ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    fill_d    = (wrt_smpl && (fill_q != CNT_WIN)) ? (fill_q + CNT_ONE) : fill_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          rd_ptr_d = win_start;
          rem_d    = CNT_WIN;
          state_d  = PRIME;
        end
      end

      PRIME: begin
        ram_re   = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        state_d  = READ;
        if (trigger) begin
          if (pending_q) ovr_d     = 1'b1;
          else           pending_d = 1'b1;
        end
      end

      READ: begin
        if (rem_q == CNT_ONE) begin
          // Final beat: a held or same-cycle trigger restarts from the
          // newest sample without a trip through IDLE.
          if (pending_q || trigger) begin
            rd_ptr_d  = win_start;
            rem_d     = CNT_WIN;
            pending_d = 1'b0;
            state_d   = PRIME;
          end else begin
            state_d = IDLE;
          end
        end else begin
          // The final beat skips the read so raddr never reaches wr_ptr.
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          rem_d    = rem_q - CNT_ONE;
          if (trigger) begin
            if (pending_q) ovr_d     = 1'b1;
            else           pending_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (flush_w) begin
      state_d   = IDLE;
      fill_d    = '0;
      pending_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rem_q     <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rem_q     <= rem_d;
      fill_q    <= fill_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    dp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_ram (
      .clk     (clk),
      .we_i    (wrt_smpl),
      .waddr_i (wr_ptr_q),
      .wdata_i (smpl_in[ch*DATA_W +: DATA_W]),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (smpl_out[ch*DATA_W +: DATA_W])
    );
  end

  assign sequencing = (state_q == READ);
  assign last       = (state_q == READ) && (rem_q == CNT_ONE);
  assign ovr        = ovr_q;

endmodule

// File: tb/tb_smpl_window_queue.sv
// tb/tb_smpl_window_queue.sv - self-checking bench for smpl_window_queue
module tb_smpl_window_queue;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int WIN    = 5;
  localparam int W      = NUM_CH * DATA_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wrt_smpl;
  logic [W-1:0] smpl_in;
  logic [W-1:0] smpl_out;
  logic         sequencing;
  logic         last;
  logic         ovr;
`ifdef QUEUE_FLUSH_EN
  logic         flush;
`endif

  always #5 clk = ~clk;

  smpl_window_queue #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .WIN    (WIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef QUEUE_FLUSH_EN
    .flush      (flush),
`endif
    .wrt_smpl   (wrt_smpl),
    .smpl_in    (smpl_in),
    .smpl_out   (smpl_out),
    .sequencing (sequencing),
    .last       (last),
    .ovr        (ovr)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: a burst is a scheduled interval of output cycles with a
  // snapshot of the newest WIN samples taken when it is launched.
  logic [W-1:0] hist[$];
  logic [W-1:0] win_snap[WIN];
  int           bstart  = -100;
  int           bend    = -100;
  int           fill    = 0;
  bit           pending = 1'b0;
  bit           m_ovr   = 1'b0;
  int           bursts  = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    bstart  = -100;
    bend    = -100;
    fill    = 0;
    pending = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic launch();
    bstart = cyc;
    bend   = cyc + WIN + 1;
    bursts++;
    for (int i = 0; i < WIN; i++) win_snap[i] = hist[i];
  endtask

  task automatic model_step(input bit wr, input logic [W-1:0] d, input bit fl);
    bit trig;
    trig = wr && (fill >= WIN - 1);
    if (fl) begin
      model_reset();
      return;
    end
    if (wr) begin
      hist.push_back(d);
      if (hist.size() > WIN) void'(hist.pop_front());
      if (fill < WIN) fill++;
    end
    if (cyc == bend && (pending || trig)) begin
      launch();
      pending = 1'b0;
    end else if (trig) begin
      if (cyc > bend)   launch();
      else if (pending) m_ovr = 1'b1;
      else              pending = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit eseq;
    eseq = (cyc >= bstart + 2) && (cyc <= bend);
    check_val("sequencing", W'(sequencing), W'(eseq));
    check_val("last", W'(last), W'(eseq && (cyc == bend)));
    check_val("ovr", W'(ovr), W'(m_ovr));
    if (eseq) check_val("smpl_out", smpl_out, win_snap[cyc - bstart - 2]);
  endtask

  // Called at a negedge: check this cycle, drive inputs, advance one clock.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit fl);
    check_outputs();
    wrt_smpl = wr;
    smpl_in  = d;
`ifdef QUEUE_FLUSH_EN
    flush    = fl;
`endif
    model_step(wr, d, fl);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] pk(input int n);
    return {16'(16'h100 + n), 16'(n)};
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    smpl_in  = '0;
`ifdef QUEUE_FLUSH_EN
    flush    = 1'b0;
`endif
    #1;
    check_val("rst_sequencing", W'(sequencing), '0);
    check_val("rst_last", W'(last), '0);
    check_val("rst_ovr", W'(ovr), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
  endtask

  initial begin
    int b0;
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    smpl_in  = '0;
`ifdef QUEUE_FLUSH_EN
    flush    = 1'b0;
`endif
    @(negedge clk);
    do_reset();

    // Fill: four writes produce nothing, the fifth launches a burst.
    for (int n = 1; n <= 4; n++) begin
      step(1'b1, pk(n), 1'b0);
      idle(2);
    end
    b0 = bursts;
    step(1'b1, pk(5), 1'b0);
    check_val("first_burst_launched", W'(bursts - b0), W'(1));
    idle(9);

    // Slow steady writes, wrapping the RAM several times.
    for (int n = 6; n <= 40; n++) begin
      step(1'b1, pk(n), 1'b0);
      idle(9);
    end
    check_val("no_ovr_steady", W'(ovr), '0);

    // One extra trigger during a burst becomes pending.
    step(1'b1, pk(41), 1'b0);
    idle(2);
    step(1'b1, pk(42), 1'b0);
    idle(20);
    check_val("no_ovr_pending", W'(ovr), '0);

    // Two extra triggers during a burst: second one overruns.
    step(1'b1, pk(43), 1'b0);
    idle(2);
    step(1'b1, pk(44), 1'b0);
    step(1'b1, pk(45), 1'b0);
    idle(20);
    check_val("ovr_sticky", W'(ovr), W'(1));
    step(1'b1, pk(46), 1'b0);
    idle(10);

    // Trigger exactly on the final beat of a burst.
    step(1'b1, pk(47), 1'b0);
    idle(WIN);
    step(1'b1, pk(48), 1'b0);
    idle(12);

    // Reset in the middle of a burst.
    step(1'b1, pk(49), 1'b0);
    idle(3);
    @(negedge clk);
    do_reset();
    for (int n = 50; n <= 53; n++) step(1'b1, pk(n), 1'b0);
    idle(4);
    b0 = bursts;
    step(1'b1, pk(54), 1'b0);
    check_val("refill_burst", W'(bursts - b0), W'(1));
    idle(10);

`ifdef QUEUE_FLUSH_EN
    // Flush mid-burst with a same-cycle write.
    step(1'b1, pk(60), 1'b0);
    idle(3);
    step(1'b1, pk(61), 1'b1);
    check_val("flush_seq", W'(sequencing), '0);
    for (int n = 62; n <= 65; n++) step(1'b1, pk(n), 1'b0);
    b0 = bursts;
    step(1'b1, pk(66), 1'b0);
    check_val("flush_refill", W'(bursts - b0), W'(1));
    idle(10);
`endif

    // Randomised traffic with occasional reset/flush.
    for (int i = 0; i < 3000; i++) begin
      bit          wr;
      bit          fl;
      logic [W-1:0] d;
      wr = ($urandom_range(0, 2) == 0);
      d  = W'($urandom());
      fl = 1'b0;
`ifdef QUEUE_FLUSH_EN
      fl = ($urandom_range(0, 149) == 0);
`endif
      if ($urandom_range(0, 499) == 0) do_reset();
      else step(wr, d, fl);
    end
    idle(12);
    check_val("bursts_seen", W'(bursts > 20), W'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
